// File: rtl/ip_pkg.sv
// Shared constants, controller state encoding and frame geometry helper
// for the 3x3 median frame controller.
package ip_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned KSIZE = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // Number of full-window medians produced by a w x h frame.
  function automatic int unsigned res_count(input int unsigned w, input int unsigned h);
    return (w - (KSIZE - 1)) * (h - (KSIZE - 1));
  endfunction

endpackage

// File: rtl/pix_pos_tracker.sv
// Raster row/column counters for consumed pixels; flags pixels that
// complete a full KSIZE x KSIZE window.
module pix_pos_tracker
  import ip_pkg::*;
#(
  parameter int unsigned IMG_W = 150,
  parameter int unsigned IMG_H = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic adv_i,
  output logic win_full_c_o
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Position of the pixel being consumed this cycle.
  assign win_full_c_o = (row_q >= ROW_W'(KSIZE - 1)) && (col_q >= COL_W'(KSIZE - 1));

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame sequencer: streams a raster frame into the window/sorter pair and
// writes full-window medians to a result memory with backpressure.
module median_frame_ctrl
  import ip_pkg::*;
#(
  parameter int unsigned IMG_W    = 150,
  parameter int unsigned IMG_H    = 100,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned SORT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_en,
  input  logic [PIX_W-1:0]  med_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [PIX_W-1:0]  res_data
);

  localparam int unsigned N_PIX = IMG_W * IMG_H;
  localparam int unsigned RES_N = res_count(IMG_W, IMG_H);
  localparam int unsigned DC_W  = $clog2(SORT_LAT + 1);
  localparam logic [ADDR_W-1:0] PIX_END  = ADDR_W'(N_PIX);
  localparam logic [ADDR_W-1:0] RES_LAST = ADDR_W'(RES_N - 1);
  localparam logic [DC_W-1:0]   DRAIN_N  = DC_W'(SORT_LAT);

  ctrl_state_t         state_q;
  logic [ADDR_W-1:0]   rd_cnt_q;
  logic [ADDR_W-1:0]   res_addr_q;
  logic                avail_q;
  logic [DC_W-1:0]     drain_cnt_q;
  logic [SORT_LAT-1:0] vpipe_q;
  logic                res_valid_q;
  logic [PIX_W-1:0]    res_data_q;
  logic                busy_q;
  logic                done_q;

  logic adv_c, rd_en_c, pix_en_c, xfer_c, last_pix_c, track_en_c;
  logic start_c, shift_in_c, win_full_c;

  // Pipeline advance, fetch and consume decisions for this cycle.
  always_comb begin
    adv_c      = 1'b0;
    rd_en_c    = 1'b0;
    pix_en_c   = 1'b0;
    start_c    = (state_q == IDLE) && start;
    xfer_c     = res_valid_q && res_ready;
    if ((state_q == RUN) || (state_q == DRAIN)) begin
      adv_c = !res_valid_q || res_ready;
    end
    if (state_q == RUN) begin
      rd_en_c  = adv_c && (rd_cnt_q < PIX_END) && !avail_q;
      pix_en_c = adv_c && avail_q;
    end else if (state_q == DRAIN) begin
      pix_en_c = adv_c && (drain_cnt_q != DRAIN_N);
    end
    track_en_c = pix_en_c && (state_q == RUN);
    last_pix_c = track_en_c && (rd_cnt_q == PIX_END);
    shift_in_c = track_en_c && win_full_c;
  end

  pix_pos_tracker #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_c),
    .adv_i       (track_en_c),
    .win_full_c_o(win_full_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      res_addr_q  <= '0;
      avail_q     <= 1'b0;
      drain_cnt_q <= '0;
      vpipe_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            rd_cnt_q    <= '0;
            res_addr_q  <= '0;
            avail_q     <= 1'b0;
            drain_cnt_q <= '0;
            vpipe_q     <= '0;
          end
        end
        RUN: begin
          if (last_pix_c) state_q <= DRAIN;
        end
        DRAIN: begin
          // The last median is captured on the final flush cycle, so its
          // transfer always lands here.
          if (xfer_c && (res_addr_q == RES_LAST)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (rd_en_c) begin
        rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
        avail_q  <= 1'b1;
      end else if (track_en_c) begin
        avail_q  <= 1'b0;
      end

      if (pix_en_c) begin
        vpipe_q <= (vpipe_q << 1) | SORT_LAT'(shift_in_c);
        if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + DC_W'(1);
      end

      // Capture only happens when the output register is free or draining.
      if (pix_en_c && vpipe_q[SORT_LAT-1]) begin
        res_valid_q <= 1'b1;
        res_data_q  <= med_in;
      end else if (xfer_c) begin
        res_valid_q <= 1'b0;
      end

      if (xfer_c) res_addr_q <= res_addr_q + ADDR_W'(1);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_c;
  assign rd_addr   = rd_cnt_q;
  assign pix_out   = (state_q == RUN) ? rd_data : '0;
  assign pix_en    = pix_en_c;
  assign res_valid = res_valid_q;
  assign res_addr  = res_addr_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl: 5x4, 150x100 and 3x3 instances, each with a
// pixel memory, a window+sorter stand-in and a result monitor.
module tb_median_frame_ctrl;

  localparam int unsigned AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s       [3];
  logic          start_s     [3];
  logic          busy_s      [3];
  logic          done_s      [3];
  logic          rd_en_s     [3];
  logic [AW-1:0] rd_addr_s   [3];
  logic [7:0]    rd_data_s   [3];
  logic [7:0]    pix_out_s   [3];
  logic          pix_en_s    [3];
  logic [7:0]    med_in_s    [3];
  logic          res_valid_s [3];
  logic          res_ready_s [3];
  logic [AW-1:0] res_addr_s  [3];
  logic [7:0]    res_data_s  [3];

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_small [6] = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 5 : ((gi == 1) ? 150 : 3);
    localparam int H = (gi == 0) ? 4 : ((gi == 1) ? 100 : 3);
    localparam bit CONST_PIX = (gi == 1);

    logic [7:0] rdq = 8'd0;
    logic [7:0] med_q = 8'd0;
    logic [7:0] hist [0:16383];
    int hcnt = 0;
    int n_res = 0, addr_bad = 0, done_cnt = 0, stall_viol = 0, busy_bad = 0;
    int rd_cnt = 0, rd_bad = 0;
    bit busy_prev = 1'b0;
    logic [7:0] res_mem [0:16383];
    int hits [0:16383];

    median_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SORT_LAT(2)) u_dut (
      .clk(clk), .rst(rst_s[gi]), .start(start_s[gi]), .busy(busy_s[gi]), .done(done_s[gi]),
      .rd_en(rd_en_s[gi]), .rd_addr(rd_addr_s[gi]), .rd_data(rd_data_s[gi]),
      .pix_out(pix_out_s[gi]), .pix_en(pix_en_s[gi]), .med_in(med_in_s[gi]),
      .res_valid(res_valid_s[gi]), .res_ready(res_ready_s[gi]),
      .res_addr(res_addr_s[gi]), .res_data(res_data_s[gi])
    );

    // Median of the 3x3 window whose newest pixel is stream entry k-1.
    function automatic logic [7:0] med_of(input int k);
      int v [9];
      int last, t;
      last = k - 1;
      if (last < 2 * W + 2) return 8'd0;
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++) v[j*3+i] = int'(hist[last - j*W - i]);
      for (int a = 0; a < 9; a++)
        for (int b = 0; b < 8 - a; b++)
          if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
      return 8'(v[4]);
    endfunction

    always @(posedge clk) begin
      if (rd_en_s[gi]) rdq <= CONST_PIX ? 8'h80 : 8'(rd_addr_s[gi]);
      if (rst_s[gi]) begin
        med_q <= 8'd0;
        hcnt  <= 0;
      end else if (start_s[gi] && !busy_s[gi]) begin
        hcnt  <= 0;
      end else if (pix_en_s[gi]) begin
        med_q      <= med_of(hcnt);
        hist[hcnt] <= pix_out_s[gi];
        hcnt       <= hcnt + 1;
      end
    end
    assign rd_data_s[gi] = rdq;
    assign med_in_s[gi]  = med_q;

    always @(negedge clk) begin
      if (start_s[gi] && !busy_s[gi] && !rst_s[gi]) begin
        n_res = 0; addr_bad = 0; done_cnt = 0; stall_viol = 0; busy_bad = 0;
        rd_cnt = 0; rd_bad = 0;
        for (int a = 0; a < 16384; a++) hits[a] = 0;
      end else if (!rst_s[gi]) begin
        if (res_valid_s[gi] && res_ready_s[gi]) begin
          if (res_addr_s[gi] != AW'(n_res)) addr_bad++;
          if (n_res < 16384) res_mem[n_res] = res_data_s[gi];
          n_res++;
        end
        if (done_s[gi]) begin
          done_cnt++;
          if (busy_s[gi] || !busy_prev) busy_bad++;
        end
        if (pix_en_s[gi] && res_valid_s[gi] && !res_ready_s[gi]) stall_viol++;
        if (rd_en_s[gi]) begin
          if (int'(rd_addr_s[gi]) >= W * H) rd_bad++;
          else hits[rd_addr_s[gi]]++;
          rd_cnt++;
        end
      end
      busy_prev = busy_s[gi];
    end
  end

  function automatic logic [63:0] outs_of(input int i);
    return 64'({busy_s[i], done_s[i], rd_en_s[i], rd_addr_s[i], pix_out_s[i], pix_en_s[i],
                res_valid_s[i], res_addr_s[i], res_data_s[i]});
  endfunction

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start_s[i] = 1'b1;
    @(posedge clk); #1 start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (toggle) res_ready_s[i] = (c % 3 == 2);
      if (done_s[i]) begin ok = 1'b1; break; end
    end
    res_ready_s[i] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (outs_of(i) !== 64'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs inst %0d: got %h want 0", i, outs_of(i));
      end
    end
  endtask

  task automatic test_frame_basic();
    bit ok;
    tests_run++;
    if (busy_s[0] !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b want 0", busy_s[0]); end
    pulse_start(0);
    tests_run++;
    if (busy_s[0] !== 1'b1) begin tests_failed++; $display("FAIL busy_after_start: got %b want 1", busy_s[0]); end
    wait_done(0, 1000, 1'b0, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_timeout: done not seen"); end
    tests_run++;
    if (g_cfg[0].n_res != 6) begin tests_failed++; $display("FAIL basic_count: got %0d want 6", g_cfg[0].n_res); end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (g_cfg[0].res_mem[k] !== exp_small[k]) begin
        tests_failed++;
        $display("FAIL basic_median[%0d]: got %0d want %0d", k, g_cfg[0].res_mem[k], exp_small[k]);
      end
    end
    tests_run++;
    if (g_cfg[0].addr_bad != 0) begin tests_failed++; $display("FAIL basic_addr_order: %0d out of sequence, want 0", g_cfg[0].addr_bad); end
    tests_run++;
    if (g_cfg[0].done_cnt != 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d want 1", g_cfg[0].done_cnt); end
    tests_run++;
    if (g_cfg[0].busy_bad != 0) begin tests_failed++; $display("FAIL basic_busy_with_done: got %0d bad want 0", g_cfg[0].busy_bad); end
    tests_run++;
    if (g_cfg[0].rd_cnt != 20) begin tests_failed++; $display("FAIL basic_reads: got %0d want 20", g_cfg[0].rd_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    pulse_start(0);
    wait_done(0, 3000, 1'b1, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_timeout: done not seen"); end
    tests_run++;
    if (g_cfg[0].n_res != 6) begin tests_failed++; $display("FAIL bp_count: got %0d want 6", g_cfg[0].n_res); end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (g_cfg[0].res_mem[k] !== exp_small[k]) begin
        tests_failed++;
        $display("FAIL bp_median[%0d]: got %0d want %0d", k, g_cfg[0].res_mem[k], exp_small[k]);
      end
    end
    tests_run++;
    if (g_cfg[0].addr_bad != 0) begin tests_failed++; $display("FAIL bp_addr_order: %0d out of sequence, want 0", g_cfg[0].addr_bad); end
    tests_run++;
    if (g_cfg[0].stall_viol != 0) begin tests_failed++; $display("FAIL bp_pix_en_stalled: got %0d want 0", g_cfg[0].stall_viol); end
    tests_run++;
    if (g_cfg[0].done_cnt != 1) begin tests_failed++; $display("FAIL bp_done_count: got %0d want 1", g_cfg[0].done_cnt); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    pulse_start(0);
    repeat (15) @(posedge clk);
    pulse_start(0);
    wait_done(0, 1000, 1'b0, ok);
    repeat (40) @(negedge clk);
    #1;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL restart_timeout: done not seen"); end
    tests_run++;
    if (g_cfg[0].n_res != 6) begin tests_failed++; $display("FAIL restart_count: got %0d want 6", g_cfg[0].n_res); end
    tests_run++;
    if (g_cfg[0].done_cnt != 1) begin tests_failed++; $display("FAIL restart_done_count: got %0d want 1", g_cfg[0].done_cnt); end
    tests_run++;
    if (busy_s[0] !== 1'b0) begin tests_failed++; $display("FAIL restart_busy_after: got %b want 0", busy_s[0]); end
    tests_run++;
    if (g_cfg[0].res_mem[5] !== 8'd13) begin tests_failed++; $display("FAIL restart_last_median: got %0d want 13", g_cfg[0].res_mem[5]); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int c;
    pulse_start(0);
    c = 0;
    while (g_cfg[0].n_res < 3 && c < 500) begin @(negedge clk); #1; c++; end
    tests_run++;
    if (g_cfg[0].n_res < 3) begin tests_failed++; $display("FAIL abort_wait: got %0d results want 3", g_cfg[0].n_res); end
    @(posedge clk); #1 rst_s[0] = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (outs_of(0) !== 64'd0) begin tests_failed++; $display("FAIL abort_outputs: got %h want 0", outs_of(0)); end
    rst_s[0] = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    tests_run++;
    if (g_cfg[0].done_cnt != 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d want 0", g_cfg[0].done_cnt); end
    tests_run++;
    if (rd_en_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      tests_failed++; $display("FAIL abort_quiet: rd_en %b busy %b want 0 0", rd_en_s[0], busy_s[0]);
    end
    pulse_start(0);
    wait_done(0, 1000, 1'b0, ok);
    tests_run++;
    if (!ok || g_cfg[0].n_res != 6) begin
      tests_failed++; $display("FAIL abort_rerun_count: done %b got %0d want 6", ok, g_cfg[0].n_res);
    end
    tests_run++;
    if (g_cfg[0].addr_bad != 0) begin tests_failed++; $display("FAIL abort_rerun_addr: %0d out of sequence, want 0", g_cfg[0].addr_bad); end
    tests_run++;
    if (g_cfg[0].res_mem[0] !== 8'd6) begin tests_failed++; $display("FAIL abort_rerun_first: got %0d want 6", g_cfg[0].res_mem[0]); end
  endtask

  task automatic test_min_frame();
    bit ok;
    pulse_start(2);
    wait_done(2, 500, 1'b0, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL min_timeout: done not seen"); end
    tests_run++;
    if (g_cfg[2].n_res != 1) begin tests_failed++; $display("FAIL min_count: got %0d want 1", g_cfg[2].n_res); end
    tests_run++;
    if (g_cfg[2].res_mem[0] !== 8'd4) begin tests_failed++; $display("FAIL min_median: got %0d want 4", g_cfg[2].res_mem[0]); end
    tests_run++;
    if (g_cfg[2].addr_bad != 0 || g_cfg[2].done_cnt != 1) begin
      tests_failed++; $display("FAIL min_addr_done: addr_bad %0d done %0d want 0 1", g_cfg[2].addr_bad, g_cfg[2].done_cnt);
    end
  endtask

  task automatic test_big_frame();
    bit ok;
    int bad;
    pulse_start(1);
    wait_done(1, 40000, 1'b0, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL big_timeout: done not seen"); end
    tests_run++;
    if (g_cfg[1].n_res != 14504) begin tests_failed++; $display("FAIL big_count: got %0d want 14504", g_cfg[1].n_res); end
    bad = 0;
    for (int k = 0; k < 14504; k++) if (g_cfg[1].res_mem[k] !== 8'h80) bad++;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL big_values: %0d not 0x80, want 0", bad); end
    tests_run++;
    if (g_cfg[1].addr_bad != 0) begin tests_failed++; $display("FAIL big_addr_order: %0d out of sequence, want 0", g_cfg[1].addr_bad); end
    bad = 0;
    for (int a = 0; a < 15000; a++) if (g_cfg[1].hits[a] != 1) bad++;
    tests_run++;
    if (bad != 0 || g_cfg[1].rd_bad != 0 || g_cfg[1].rd_cnt != 15000) begin
      tests_failed++;
      $display("FAIL big_read_cover: %0d addrs not once, %0d out of range, %0d reads want 0 0 15000",
               bad, g_cfg[1].rd_bad, g_cfg[1].rd_cnt);
    end
    tests_run++;
    if (g_cfg[1].done_cnt != 1) begin tests_failed++; $display("FAIL big_done_count: got %0d want 1", g_cfg[1].done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1;
      start_s[i] = 1'b0;
      res_ready_s[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_frame_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
    test_min_frame();
    test_big_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
